rsp_framer: RTL and testbench
=============================

Name: rsp_framer

Overview:
- Transmit-side counterpart of the command parser: turns one response request (opcode, length, payload) into a framed byte stream for the 10 MHz UART transmitter.
- Sits between the command logic and the uart_tx instance. Drives its data-valid strobe and byte, and paces itself on the transmitter's active/done handshake.
- Gives the host a checksummed, self-delimiting reply.
- Includes a per-byte watchdog so a stalled transmitter cannot hang the command path.

Parameters:
- HEADER, 8'hA5, first byte of every frame.
- MAX_LEN, 4, maximum payload bytes accepted.
- TIMEOUT_CYCLES, 2048, clk cycles allowed between a byte strobe and its tx_done.

Ports:
- clk  in  1  UART-domain clock (10 MHz)
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle request strobe
- i_opcode  in  8  opcode echoed in frame
- i_len  in  3  payload byte count, 0..MAX_LEN
- i_payload  in  32  payload, low i_len bytes used
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse, frame fully sent
- o_err  out  1  one-cycle pulse, request rejected or watchdog abort
- o_tx_dv  out  1  one-cycle strobe to uart_tx
- o_tx_byte  out  8  byte to uart_tx
- i_tx_active  in  1  uart_tx shifting
- i_tx_done  in  1  uart_tx byte-complete pulse

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0, including o_tx_byte = 8'h00; latches and counters cleared. This applies mid-frame as well: the partial frame is abandoned and no o_done or o_err is produced.
- Frame format: HEADER, opcode, {5'b0,len}, payload bytes most significant first (i_payload[8L-1:8L-8] down to [7:0]), checksum.
  - Checksum = XOR of opcode, len byte and all payload bytes; HEADER is excluded.
  - Total frame is 4+L bytes.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE:
  - i_start sampled high at cycle T with i_len <= MAX_LEN: latch opcode, len and payload; clear byte index. At T+1: state ISSUE, o_busy=1.
  - i_len > MAX_LEN: o_err=1 at T+1 only; no frame, o_busy stays 0.
- ISSUE:
  - When i_tx_active is sampled low: next cycle o_tx_dv=1 for exactly one cycle, o_tx_byte = current frame byte, state WAIT, watchdog cleared.
  - When i_tx_active is high: hold, no strobe.
  - Best case: first o_tx_dv at T+2.
- WAIT:
  - o_tx_byte is held stable until i_tx_done.
  - On i_tx_done: if this was the last byte, go to FIN; otherwise increment the index and go to ISSUE.
  - The watchdog counts every WAIT cycle. On reaching TIMEOUT_CYCLES-1 without i_tx_done: o_err=1 for one cycle, o_busy=0, state IDLE.
- FIN: o_done=1 and o_busy=0 in the same cycle; IDLE the next cycle. A new start is accepted from that IDLE cycle.
- Simultaneous events:
  - i_start while o_busy=1 is ignored silently; the latched request is unaffected.
  - i_tx_done seen in ISSUE or IDLE is ignored.
  - i_tx_done on the same cycle the watchdog expires counts as a completion; no error.
- Width rules:
  - Byte index is 3 bits, wraps never (bounded by 4+MAX_LEN-1 = 7).
  - Watchdog width is clog2(TIMEOUT_CYCLES) and saturates.

Decomposition:
- Shared package glitch_pkg holds:
  - the HEADER constant;
  - the MAX_LEN constant;
  - the state encoding (IDLE/ISSUE/WAIT/FIN);
  - a checksum function reused by the command parser for its receive-side check.
- One natural sub-module, tx_watchdog: clear, enable, expire pulse, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Two-byte payload, tx model returns done 10 cycles after each dv.
   - Stimulus: opcode 8'h10, len 2, payload 32'h0000BEEF.
   - Required: bytes A5 10 02 BE EF 43 in order; exactly 6 dv pulses; one o_done; o_err never set.
2. Empty payload.
   - Stimulus: opcode 8'h3C, len 0.
   - Required: A5 3C 00 3C; o_done one cycle after the 4th tx_done.
3. Oversize length.
   - Stimulus: len 5.
   - Required: o_err pulse at T+1; no o_tx_dv; o_busy remains 0.
4. Stalled transmitter.
   - Stimulus: TIMEOUT_CYCLES=16, tx model never pulses done.
   - Required: o_err 16 cycles after first dv; o_busy low; no o_done; a subsequent normal request completes correctly.
5. Busy transmitter and ignored starts.
   - Stimulus: i_tx_active held high for 50 cycles at request time; extra i_start pulses while busy.
   - Required: no dv until active drops; extra starts ignored; frame bytes match the first request only.
6. Reset mid-frame.
   - Stimulus: rst_n low mid-payload.
   - Required: all outputs 0 immediately (asynchronous); no o_done or o_err; the next request with len 4, payload DEADBEEF, opcode 01 yields A5 01 04 DE AD BE EF 27.

Source files
------------

// File: rtl/glitch_pkg.sv
// Purpose: shared framing constants, FSM encoding and the frame checksum helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package glitch_pkg;

  localparam logic [7:0] HEADER  = 8'hA5;
  localparam int         MAX_LEN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } state_t;

  // XOR of opcode, length byte and the low len payload bytes; HEADER is never included.
  // The receive-side parser calls this same function, so both ends agree on coverage.
  function automatic logic [7:0] frame_checksum(input logic [7:0]  opcode,
                                                input logic [2:0]  len,
                                                input logic [31:0] payload);
    logic [7:0] c;
    c = opcode ^ {5'b00000, len};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) c = c ^ payload[8*i +: 8];
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_watchdog.sv
// Purpose: per-byte stall detector; counts enabled cycles since the last clear.
// Latency: expire is combinational once the count reaches TIMEOUT_CYCLES-1 while enabled.
// Backpressure: none; the counter saturates, so it never wraps into a false restart.
module tx_watchdog #(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Count enabled cycles, restart on clear, hold at LAST rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/rsp_framer.sv
// Purpose: frames one response (HEADER, opcode, len, payload MSB-first, checksum) onto uart_tx.
// Latency: start at T -> busy at T+1 -> first tx strobe at T+2 at best; done one cycle after last tx_done.
// Backpressure: holds in ISSUE while i_tx_active is high; new starts ignored while busy; watchdog aborts stalls.
module rsp_framer
  import glitch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_opcode,
  input  logic [2:0]  i_len,
  input  logic [31:0] i_payload,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_tx_dv,
  output logic [7:0]  o_tx_byte,
  input  logic        i_tx_active,
  input  logic        i_tx_done
);

  localparam logic [2:0] LEN_MAX = 3'(MAX_LEN);

  state_t      state;
  logic [7:0]  op_q;
  logic [2:0]  len_q;
  logic [31:0] payload_q;
  logic [2:0]  idx;

  logic [2:0]  last_idx;
  logic [2:0]  pay_sel;
  logic [7:0]  pay_byte;
  logic [7:0]  frame_byte;
  logic        wd_expire;

  // Checksum sits right after the payload; index never exceeds 3+MAX_LEN = 7.
  assign last_idx = len_q + 3'd3;
  // Payload goes out most significant byte first: index 3 carries byte len-1.
  assign pay_sel  = len_q + 3'd2 - idx;

  // Pick the payload byte addressed by the current frame index.
  always_comb begin
    pay_byte = 8'h00;
    case (pay_sel)
      3'd0:    pay_byte = payload_q[7:0];
      3'd1:    pay_byte = payload_q[15:8];
      3'd2:    pay_byte = payload_q[23:16];
      3'd3:    pay_byte = payload_q[31:24];
      default: pay_byte = 8'h00;
    endcase
  end

  // Map frame index to the byte on the wire.
  always_comb begin
    frame_byte = HEADER;
    case (idx)
      3'd0:    frame_byte = HEADER;
      3'd1:    frame_byte = op_q;
      3'd2:    frame_byte = {5'b00000, len_q};
      default: frame_byte = (idx == last_idx) ? frame_checksum(op_q, len_q, payload_q) : pay_byte;
    endcase
  end

  // Watchdog runs only while a byte is outstanding and restarts on every other state.
  tx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != WAIT),
    .enable (state == WAIT),
    .expire (wd_expire)
  );

  // Framing FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= 8'h00;
      len_q     <= 3'd0;
      payload_q <= 32'h0;
      idx       <= 3'd0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_tx_dv   <= 1'b0;
      o_tx_byte <= 8'h00;
    end else begin
      o_tx_dv <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_len > LEN_MAX) begin
              o_err <= 1'b1;
            end else begin
              op_q      <= i_opcode;
              len_q     <= i_len;
              payload_q <= i_payload;
              idx       <= 3'd0;
              o_busy    <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!i_tx_active) begin
            o_tx_dv   <= 1'b1;
            o_tx_byte <= frame_byte;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A completion on the expiry cycle wins over the abort.
          if (i_tx_done) begin
            if (idx == last_idx) begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= FIN;
            end else begin
              idx   <= idx + 3'd1;
              state <= ISSUE;
            end
          end else if (wd_expire) begin
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsp_framer.sv
module tb_rsp_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [7:0]  i_opcode;
  logic [2:0]  i_len;
  logic [31:0] i_payload;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_tx_dv;
  logic [7:0]  o_tx_byte;
  logic        i_tx_active;
  logic        i_tx_done;

  rsp_framer #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_opcode    (i_opcode),
    .i_len       (i_len),
    .i_payload   (i_payload),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_tx_dv     (o_tx_dv),
    .o_tx_byte   (o_tx_byte),
    .i_tx_active (i_tx_active),
    .i_tx_done   (i_tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int  dv_cnt = 0, done_cnt = 0, err_cnt = 0;
  int  last_dv_cyc = 0, done_cyc = 0, err_cyc = 0, last_txdone_cyc = 0;
  int  tx_cnt = 0;
  bit  stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor + uart_tx model: pop expected bytes on every strobe, answer with done 10 cycles later.
  initial begin
    logic [7:0] e;
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_dv) begin
        dv_cnt++;
        last_dv_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", o_tx_byte);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", {24'h0, o_tx_byte}, {24'h0, e});
        end
      end
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (o_err)  begin err_cnt++;  err_cyc  = cyc; end
      i_tx_done = 1'b0;
      if (!rst_n) begin
        tx_cnt = 0;
      end else if (o_tx_dv) begin
        tx_cnt = stall ? 0 : 10;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          i_tx_done = 1'b1;
          last_txdone_cyc = cyc;
        end
      end
    end
  end

  task automatic push_frame(input int n, input logic [63:0] b);
    for (int i = 0; i < n; i++) exp_q.push_back(b[63-8*i -: 8]);
  endtask

  task automatic send(input logic [7:0] op, input logic [2:0] len, input logic [31:0] pl);
    @(negedge clk);
    i_start   = 1'b1;
    i_opcode  = op;
    i_len     = len;
    i_payload = pl;
    @(negedge clk);
    i_start   = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int d0, e0;
    bit hit;
    d0 = done_cnt;
    e0 = err_cnt;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0 || err_cnt != e0) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done/err expected one within %0d cycles", name, budget);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_busy"}, {31'h0, o_busy},  32'h0);
    check({name, "_done"}, {31'h0, o_done},  32'h0);
    check({name, "_err"},  {31'h0, o_err},   32'h0);
    check({name, "_dv"},   {31'h0, o_tx_dv}, 32'h0);
    check({name, "_byte"}, {24'h0, o_tx_byte}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int dv0, d0, e0;
    bit hit;
    rst_n = 1'b0; i_start = 1'b0; i_opcode = 8'h00; i_len = 3'd0;
    i_payload = 32'h0; i_tx_active = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: two-byte payload
    push_frame(6, 64'hA5_10_02_BE_EF_43_00_00);
    dv0 = dv_cnt; d0 = done_cnt; e0 = err_cnt;
    send(8'h10, 3'd2, 32'h0000BEEF);
    check("t1_busy_T1", {31'h0, o_busy}, 32'h1);
    wait_end("t1", 400);
    check("t1_dv_count", dv_cnt - dv0, 6);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_err_count", err_cnt - e0, 0);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_busy_fin", {31'h0, o_busy}, 32'h0);

    // 2: empty payload, done one cycle after the 4th tx_done
    push_frame(4, 64'hA5_3C_00_3C_00_00_00_00);
    dv0 = dv_cnt; d0 = done_cnt;
    send(8'h3C, 3'd0, 32'h0);
    wait_end("t2", 300);
    check("t2_dv_count", dv_cnt - dv0, 4);
    check("t2_done_count", done_cnt - d0, 1);
    check("t2_done_timing", done_cyc - last_txdone_cyc, 1);

    // 3: oversize length rejected
    dv0 = dv_cnt;
    send(8'h77, 3'd5, 32'h11223344);
    check("t3_err_T1", {31'h0, o_err}, 32'h1);
    check("t3_busy_T1", {31'h0, o_busy}, 32'h0);
    @(negedge clk);
    check("t3_err_T2", {31'h0, o_err}, 32'h0);
    check("t3_busy_T2", {31'h0, o_busy}, 32'h0);
    repeat (5) @(negedge clk);
    #1;
    check("t3_no_dv", dv_cnt - dv0, 0);

    // 4: stalled transmitter, then a normal request
    stall = 1'b1;
    push_frame(1, 64'hA5_00_00_00_00_00_00_00);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h55, 3'd1, 32'h0000_0099);
    wait_end("t4", 100);
    check("t4_err_count", err_cnt - e0, 1);
    check("t4_err_timing", err_cyc - last_dv_cyc, 16);
    check("t4_busy", {31'h0, o_busy}, 32'h0);
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_queue_empty", exp_q.size(), 0);
    stall = 1'b0;
    push_frame(5, 64'hA5_22_01_07_24_00_00_00);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h22, 3'd1, 32'h0000_0007);
    wait_end("t4b", 300);
    check("t4b_done_count", done_cnt - d0, 1);
    check("t4b_err_count", err_cnt - e0, 0);

    // 5: transmitter busy at request time, extra starts ignored
    @(negedge clk);
    i_tx_active = 1'b1;
    push_frame(7, 64'hA5_5A_03_12_34_56_29_00);
    dv0 = dv_cnt; d0 = done_cnt;
    send(8'h5A, 3'd3, 32'h0012_3456);
    for (int k = 0; k < 3; k++) begin
      send(8'hFF, 3'd1, 32'hFFFF_FFFF);
      repeat (10) @(negedge clk);
    end
    repeat (14) @(negedge clk);
    #1;
    check("t5_no_dv_while_active", dv_cnt - dv0, 0);
    check("t5_busy_hold", {31'h0, o_busy}, 32'h1);
    i_tx_active = 1'b0;
    repeat (20) @(negedge clk);
    send(8'hEE, 3'd2, 32'h0000_ABCD);
    wait_end("t5", 500);
    check("t5_done_count", done_cnt - d0, 1);
    check("t5_dv_count", dv_cnt - dv0, 7);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: asynchronous reset mid-payload, then a full frame
    push_frame(8, 64'hA5_01_04_DE_AD_BE_EF_27);
    dv0 = dv_cnt;
    send(8'h01, 3'd4, 32'hDEAD_BEEF);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (dv_cnt >= dv0 + 5) begin hit = 1'b1; break; end
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL t6_reach_payload: got %0d strobes expected 5", dv_cnt - dv0);
    end
    #2;
    d0 = done_cnt; e0 = err_cnt;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_no_err", err_cnt - e0, 0);
    push_frame(8, 64'hA5_01_04_DE_AD_BE_EF_27);
    dv0 = dv_cnt; d0 = done_cnt; e0 = err_cnt;
    send(8'h01, 3'd4, 32'hDEAD_BEEF);
    wait_end("t6", 500);
    check("t6_done_count", done_cnt - d0, 1);
    check("t6_err_count", err_cnt - e0, 0);
    check("t6_dv_count", dv_cnt - dv0, 8);
    check("t6_queue_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
